// File: rtl/product_accumulator.sv
// Batch accumulator for multiplier products: sums COUNT accepted products and
// presents the wrapped sum plus a sticky overflow flag on a valid/ready port.
module product_accumulator #(
  parameter int unsigned PROD_W = 8,
  parameter int unsigned ACC_W  = 12,
  parameter int unsigned COUNT  = 4,
  parameter int unsigned CNT_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PROD_W-1:0] product,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              clr,
  output logic [ACC_W-1:0]  sum,
  output logic              ovf,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam int unsigned SumW = ACC_W + 1;

  typedef enum logic {StAccum = 1'b0, StHold = 1'b1} state_e;

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [ACC_W-1:0]   sum_q, sum_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_acc_q, ovf_acc_d;
  logic               ovf_q, ovf_d;
  logic               out_valid_q, out_valid_d;

  logic [SumW-1:0]    add_full;
  logic               accept;
  logic               last;

  // Extra top bit captures the carry-out of each addition.
  assign add_full = {1'b0, acc_q} + SumW'(product);
  assign in_ready = (state_q == StAccum);
  assign accept   = in_valid & in_ready;
  assign last     = (cnt_q == CNT_W'(COUNT - 1));

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    sum_d       = sum_q;
    cnt_d       = cnt_q;
    ovf_acc_d   = ovf_acc_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    case (state_q)
      StAccum: begin
        if (clr) begin
          acc_d     = '0;
          cnt_d     = '0;
          ovf_acc_d = 1'b0;
        end else if (accept) begin
          if (last) begin
            sum_d       = add_full[ACC_W-1:0];
            ovf_d       = ovf_acc_q | add_full[ACC_W];
            out_valid_d = 1'b1;
            acc_d       = '0;
            cnt_d       = '0;
            ovf_acc_d   = 1'b0;
            state_d     = StHold;
          end else begin
            acc_d     = add_full[ACC_W-1:0];
            ovf_acc_d = ovf_acc_q | add_full[ACC_W];
            cnt_d     = cnt_q + CNT_W'(1);
          end
        end
      end
      StHold: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = StAccum;
        end
      end
      default: state_d = StAccum;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StAccum;
      acc_q       <= '0;
      sum_q       <= '0;
      cnt_q       <= '0;
      ovf_acc_q   <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      sum_q       <= sum_d;
      cnt_q       <= cnt_d;
      ovf_acc_q   <= ovf_acc_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign sum       = sum_q;
  assign ovf       = ovf_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_product_accumulator.sv
// Bench for product_accumulator: two instances (default and ACC_W=10/COUNT=8)
// share stimulus and are checked every cycle against a batch-level model.
module tb_product_accumulator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  product = '0;
  logic        in_valid = 1'b0;
  logic        clr = 1'b0;
  logic        out_ready = 1'b0;

  logic        in_ready_a, ovf_a, out_valid_a;
  logic [11:0] sum_a;
  logic        in_ready_b, ovf_b, out_valid_b;
  logic [9:0]  sum_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  product_accumulator dut_a (
    .clk(clk), .rst(rst), .product(product), .in_valid(in_valid),
    .in_ready(in_ready_a), .clr(clr), .sum(sum_a), .ovf(ovf_a),
    .out_valid(out_valid_a), .out_ready(out_ready)
  );

  product_accumulator #(.PROD_W(8), .ACC_W(10), .COUNT(8), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .product(product), .in_valid(in_valid),
    .in_ready(in_ready_b), .clr(clr), .sum(sum_b), .ovf(ovf_b),
    .out_valid(out_valid_b), .out_ready(out_ready)
  );

  // Model: per instance, the running integer total of the batch and its size.
  int unsigned acc_w_p [2] = '{12, 10};
  int unsigned count_p [2] = '{4, 8};
  longint      tot     [2] = '{0, 0};
  int          n       [2] = '{0, 0};
  bit          hold    [2] = '{0, 0};
  int          exp_sum [2] = '{0, 0};
  int          exp_ovf [2] = '{0, 0};

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        hold[i] = 0; tot[i] = 0; n[i] = 0; exp_sum[i] = 0; exp_ovf[i] = 0;
      end else if (hold[i]) begin
        if (out_ready) hold[i] = 0;
      end else if (clr) begin
        tot[i] = 0; n[i] = 0;
      end else if (in_valid) begin
        tot[i] = tot[i] + longint'(product);
        n[i]   = n[i] + 1;
        if (n[i] == int'(count_p[i])) begin
          exp_sum[i] = int'(tot[i] % (longint'(1) << acc_w_p[i]));
          exp_ovf[i] = (tot[i] >= (longint'(1) << acc_w_p[i])) ? 1 : 0;
          hold[i] = 1; tot[i] = 0; n[i] = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("a_in_ready", int'(in_ready_a), hold[0] ? 0 : 1);
      chk("a_out_valid", int'(out_valid_a), hold[0] ? 1 : 0);
      chk("a_sum", int'(sum_a), exp_sum[0]);
      chk("a_ovf", int'(ovf_a), exp_ovf[0]);
      chk("b_in_ready", int'(in_ready_b), hold[1] ? 0 : 1);
      chk("b_out_valid", int'(out_valid_b), hold[1] ? 1 : 0);
      chk("b_sum", int'(sum_b), exp_sum[1]);
      chk("b_ovf", int'(ovf_b), exp_ovf[1]);
    end
  end

  task automatic cyc(input logic v, input logic [7:0] p, input logic c, input logic r);
    in_valid = v; product = p; clr = c; out_ready = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", int'(out_valid_a), 0);
    chk("rst_sum", int'(sum_a), 0);
    rst = 1'b0;
    chk("rst_rel_ready", int'(in_ready_a), 1);

    // 1: four products of 225
    repeat (4) cyc(1'b1, 8'd225, 1'b0, 1'b1);
    chk("t1_valid", int'(out_valid_a), 1);
    chk("t1_sum", int'(sum_a), 900);
    chk("t1_ovf", int'(ovf_a), 0);
    chk("t1_not_ready", int'(in_ready_a), 0);
    cyc(1'b0, 8'd0, 1'b0, 1'b1);
    chk("t1_vfall", int'(out_valid_a), 0);
    chk("t1_ready", int'(in_ready_a), 1);
    chk("t1_sum_kept", int'(sum_a), 900);

    // 2: gaps between products
    for (int k = 1; k <= 4; k++) begin
      cyc(1'b1, 8'(k), 1'b0, 1'b1);
      if (k < 4) repeat (2) cyc(1'b0, 8'd0, 1'b0, 1'b1);
    end
    chk("t2_valid", int'(out_valid_a), 1);
    chk("t2_sum", int'(sum_a), 10);
    cyc(1'b0, 8'd0, 1'b0, 1'b1);

    // 3: backpressure
    repeat (4) cyc(1'b1, 8'd1, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      cyc(1'b1, 8'd99, 1'b0, 1'b0);
      chk("t3_valid", int'(out_valid_a), 1);
      chk("t3_sum", int'(sum_a), 4);
      chk("t3_not_ready", int'(in_ready_a), 0);
    end
    cyc(1'b0, 8'd0, 1'b0, 1'b1);
    chk("t3_vfall", int'(out_valid_a), 0);
    chk("t3_ready", int'(in_ready_a), 1);

    // 4: clr discards partial batch and the product presented with it
    cyc(1'b0, 8'd0, 1'b1, 1'b1);
    cyc(1'b1, 8'd7, 1'b0, 1'b1);
    cyc(1'b1, 8'd9, 1'b0, 1'b1);
    cyc(1'b1, 8'd50, 1'b1, 1'b1);
    repeat (4) cyc(1'b1, 8'd1, 1'b0, 1'b1);
    chk("t4_valid", int'(out_valid_a), 1);
    chk("t4_sum", int'(sum_a), 4);
    cyc(1'b0, 8'd0, 1'b0, 1'b1);

    // 5: wrap and sticky overflow on the narrow instance
    cyc(1'b0, 8'd0, 1'b1, 1'b1);
    repeat (8) cyc(1'b1, 8'd225, 1'b0, 1'b1);
    chk("t5_valid", int'(out_valid_b), 1);
    chk("t5_sum", int'(sum_b), 776);
    chk("t5_ovf", int'(ovf_b), 1);
    cyc(1'b0, 8'd0, 1'b0, 1'b1);
    repeat (8) cyc(1'b1, 8'd1, 1'b0, 1'b1);
    chk("t5_valid2", int'(out_valid_b), 1);
    chk("t5_sum2", int'(sum_b), 8);
    chk("t5_ovf2", int'(ovf_b), 0);
    cyc(1'b0, 8'd0, 1'b0, 1'b1);

    // 6: async reset mid-batch, then in HOLD
    cyc(1'b0, 8'd0, 1'b1, 1'b1);
    repeat (2) cyc(1'b1, 8'd3, 1'b0, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("t6_mid_sum", int'(sum_a), 0);
    chk("t6_mid_valid", int'(out_valid_a), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    chk("t6_rel_ready", int'(in_ready_a), 1);
    repeat (4) cyc(1'b1, 8'd3, 1'b0, 1'b0);
    chk("t6_sum12", int'(sum_a), 12);
    chk("t6_hold_valid", int'(out_valid_a), 1);
    #2 rst = 1'b1;
    #1;
    chk("t6_hold_sum", int'(sum_a), 0);
    chk("t6_hold_ovf", int'(ovf_a), 0);
    chk("t6_hold_valid0", int'(out_valid_a), 0);
    chk("t6_hold_valid_b", int'(out_valid_b), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    chk("t6_rel_ready2", int'(in_ready_a), 1);
    repeat (4) cyc(1'b1, 8'd5, 1'b0, 1'b1);
    chk("t6_sum20", int'(sum_a), 20);
    cyc(1'b0, 8'd0, 1'b0, 1'b1);

    // Randomized traffic
    for (int k = 0; k < 2000; k++) begin
      cyc(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0,
          ($urandom_range(0, 1) == 1) ? 8'($urandom_range(200, 255)) : 8'($urandom),
          ($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0,
          ($urandom_range(0, 9) < 6) ? 1'b1 : 1'b0);
    end

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
